// File: rtl/multdiv_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master = execute-stage issuer, slave = multdiv_iter.
interface multdiv_iter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, hi, lo, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, hi, lo, busy
   );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative shift-add multiplier / restoring divider with valid/ready handshake and flush.
// Define MULTDIV_DIV_EARLY_EN to finish divides with |a| < |b| straight from IDLE.
module multdiv_iter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MUL_STEP = 2
) (
   input logic           clk_i,
   input logic           reset_i,
   input logic           flush_i,
   multdiv_iter_if.slave bus
);
   localparam int unsigned N_MUL  = WIDTH / MUL_STEP;
   localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
   localparam int unsigned PART_W = WIDTH + MUL_STEP;
   localparam int unsigned ACC_W  = 2 * WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   // Operand magnitudes at the accept cycle
   logic             is_signed, is_div, a_neg, b_neg, accept;
   logic [WIDTH-1:0] a_abs, b_abs;

   assign is_signed = bus.op[0];
   assign is_div    = bus.op[1];
   assign a_neg     = is_signed & bus.a[WIDTH-1];
   assign b_neg     = is_signed & bus.b[WIDTH-1];
   assign a_abs     = a_neg ? -bus.a : bus.a;
   assign b_abs     = b_neg ? -bus.b : bus.b;
   assign accept    = bus.in_valid & in_ready_q & ~flush_i;

   // One multiply step: add |a| x low MUL_STEP bits of the shifting multiplier, shift right
   logic [PART_W-1:0] mul_part, mul_sum;
   logic [ACC_W-1:0]  mul_next, mul_neg;

   assign mul_part = PART_W'(opnd_q) * PART_W'(acc_q[MUL_STEP-1:0]);
   assign mul_sum  = PART_W'(acc_q[ACC_W-1:WIDTH]) + mul_part;
   assign mul_next = {mul_sum, acc_q[WIDTH-1:MUL_STEP]};
   assign mul_neg  = -mul_next;

   // One restoring divide step: acc = {remainder, dividend-shifting-into-quotient}
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_diff, rem_next;
   logic [ACC_W-1:0] div_next;

   assign rem_sh   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
   assign rem_ge   = rem_sh >= {1'b0, opnd_q};
   assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
   assign rem_next = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
   assign div_next = {rem_next, acc_q[WIDTH-2:0], rem_ge};

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      if (flush_i) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  if (!is_div) begin
                     state_d = S_MUL;
                     cnt_d   = CNT_W'(N_MUL);
                     acc_d   = {{WIDTH{1'b0}}, b_abs};
                     opnd_d  = a_abs;
                  end else if (bus.b == '0) begin
                     state_d = S_DONE;
                     lo_d    = '1;
                     hi_d    = bus.a;
`ifdef MULTDIV_DIV_EARLY_EN
                  end else if (a_abs < b_abs) begin
                     state_d = S_DONE;
                     lo_d    = '0;
                     hi_d    = bus.a;
`endif
                  end else begin
                     state_d = S_DIV;
                     cnt_d   = CNT_W'(WIDTH);
                     acc_d   = {{WIDTH{1'b0}}, a_abs};
                     opnd_d  = b_abs;
                  end
               end
            end
            S_MUL: begin
               acc_d = mul_next;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d      = S_DONE;
                  {hi_d, lo_d} = neg_res_q ? mul_neg : mul_next;
               end
            end
            S_DIV: begin
               acc_d = div_next;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               state_d = S_DONE;
               lo_d    = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d    = neg_rem_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Handshake flags are registered from the next state so they track state_q exactly
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         opnd_q      <= '0;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         opnd_q      <= opnd_d;
         neg_res_q   <= neg_res_d;
         neg_rem_q   <= neg_rem_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         in_ready_q  <= (state_d == S_IDLE);
         out_valid_q <= (state_d == S_DONE);
         busy_q      <= (state_d != S_IDLE);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed self-checking bench for multdiv_iter (WIDTH=32, MUL_STEP=2).
module tb_multdiv_iter;
   localparam int unsigned WIDTH = 32;
   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

`ifdef MULTDIV_DIV_EARLY_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 34;
`endif

   logic clk;
   logic rst;
   logic flush;
   int   n_cmp;
   int   n_err;

   multdiv_iter_if #(.WIDTH(WIDTH)) bus ();

   multdiv_iter #(.WIDTH(WIDTH), .MUL_STEP(2)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .flush_i (flush),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge: request is accepted at the coming posedge (cycle 0)
   task automatic start_op(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
      check({tag, "_accept_rdy"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op       = 2'($urandom);
      bus.a        = $urandom;
      bus.b        = $urandom;
   endtask

   // Called in cycle 1; waits for out_valid and checks latency, result, in_ready low
   task automatic wait_done(input string tag, input int lat,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cyc;
      bit rdy_seen;
      cyc      = 1;
      rdy_seen = 1'b0;
      while (!bus.out_valid && cyc < 200) begin
         if (bus.in_ready) rdy_seen = 1'b1;
         @(negedge clk);
         cyc++;
      end
      if (bus.in_ready) rdy_seen = 1'b1;
      check({tag, "_lat"}, 64'(cyc), 64'(lat));
      check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
      check({tag, "_rdy_low"}, 64'(rdy_seen), 64'd0);
   endtask

   // Handshake completes at the coming posedge (out_ready must be high)
   task automatic finish_hs(input string tag);
      @(negedge clk);
      check({tag, "_rdy_back"}, 64'(bus.in_ready), 64'd1);
      check({tag, "_ov_clr"}, 64'(bus.out_valid), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      start_op(tag, op, a, b);
      wait_done(tag, lat, exp_hi, exp_lo);
      finish_hs(tag);
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = 2'b00;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 17, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 17, 32'h4000_0000, 32'h0);
      run_op("mult_m1x1", OP_MULT, 32'hFFFF_FFFF, 32'd1, 17, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("multu_shift", OP_MULTU, 32'h1234_5678, 32'h10, 17, 32'h1, 32'h2345_6780);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'h1, 32'hFFFF_FFFD);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);
      run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 34, 32'h0, 32'hFFFF_FFFF);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);
      run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
      run_op("div_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      run_op("divu_small", OP_DIVU, 32'd3, 32'd10, EARLY_LAT, 32'd3, 32'd0);
      run_op("div_small_neg", OP_DIV, 32'hFFFF_FFF9, 32'd10, EARLY_LAT, 32'hFFFF_FFF9, 32'd0);

      // Back-pressure: result must hold while out_ready is low
      bus.out_ready = 1'b0;
      start_op("bp", OP_MULTU, 32'd6, 32'd7);
      wait_done("bp", 17, 32'd0, 32'd42);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_ov", 64'(bus.out_valid), 64'd1);
         check("bp_hold_lo", 64'(bus.lo), 64'd42);
         check("bp_hold_hi", 64'(bus.hi), 64'd0);
         check("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      finish_hs("bp");

      // Flush in cycle 10 of a divide, with a competing request that must be dropped
      start_op("fl_div", OP_DIV, 32'd100, 32'd3);
      repeat (9) @(negedge clk);
      check("fl_busy_c10", 64'(bus.busy), 64'd1);
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.op       = OP_MULTU;
      bus.a        = 32'd9;
      bus.b        = 32'd9;
      @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      check("fl_idle_rdy", 64'(bus.in_ready), 64'd1);
      check("fl_idle_busy", 64'(bus.busy), 64'd0);
      check("fl_idle_ov", 64'(bus.out_valid), 64'd0);
      run_op("fl_mul", OP_MULTU, 32'd2, 32'd3, 17, 32'd0, 32'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
